key_press_gen: RTL

KEY_PRESS_GEN -- requirements
Module: key_press_gen

---
 rtl/key_gen_pkg.sv | 23 ++
 rtl/key_press_gen_if.sv | 13 +
 rtl/key_gen_lfsr.sv | 27 ++
 rtl/key_press_gen.sv | 129 ++++++++++++
 4 files changed

// File: rtl/key_gen_pkg.sv
// Shared types and constants for the key-press generator.
package key_gen_pkg;

    localparam int unsigned KEY_NUM = 4;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned LFSR_W  = 16;

    // Taps 16,14,13,11 of a left-shifting Fibonacci register map to bits 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_BOUNCE,
        ST_HOLD,
        ST_REL_BOUNCE,
        ST_DONE
    } key_state_t;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/key_press_gen_if.sv
// Press-request handshake between a requester (master) and the generator (slave).
interface key_press_gen_if;
    import key_gen_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_key;
    logic [CNT_W-1:0] req_hold;

    modport master (output req_valid, output req_key, output req_hold, input  req_ready);
    modport slave  (input  req_valid, input  req_key, input  req_hold, output req_ready);

endinterface

// File: rtl/key_gen_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying contact-bounce noise.
module key_gen_lfsr
    import key_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    output logic [LFSR_W-1:0] o_state
);

    // An all-zero state would lock up, so a zero seed falls back to 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= SEED_EFF;
        end else begin
            r_state <= {r_state[LFSR_W-2:0], lfsr_fb(r_state)};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/key_press_gen.sv
// Push-button emulator: bounce / hold / bounce / done sequence on one of four keys.
// Bounce phases are built only when KEY_GEN_BOUNCE_EN is defined.
module key_press_gen
    import key_gen_pkg::*;
#(
    parameter int unsigned       BOUNCE_CYC = 100_000,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    key_press_gen_if.slave     req,
    output logic [KEY_NUM-1:0] key_out,
    output logic               busy,
    output logic               done
);

    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hold;
    logic [1:0]       r_idx;
    logic             r_ready;

    function automatic logic [KEY_NUM-1:0] key_vec(input logic [1:0] idx, input logic lvl);
        logic [KEY_NUM-1:0] v;
        v      = '1;
        v[idx] = lvl;
        return v;
    endfunction

`ifdef KEY_GEN_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYC - 1);

    logic [LFSR_W-1:0] w_lfsr;
    logic              w_bounce;

    key_gen_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .o_state   (w_lfsr)
    );

    // Bit 0 of the LFSR's next state, so registered key_out tracks the live LFSR bit 0.
    assign w_bounce = lfsr_fb(w_lfsr);
`endif

    assign req.req_ready = r_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_idx   <= '0;
            r_ready <= 1'b0;
            key_out <= '1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (req.req_valid && r_ready) begin
                        r_idx   <= req.req_key;
                        r_hold  <= req.req_hold;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        busy    <= 1'b1;
`ifdef KEY_GEN_BOUNCE_EN
                        r_state <= ST_PRESS_BOUNCE;
                        key_out <= key_vec(req.req_key, w_bounce);
`else
                        r_state <= ST_HOLD;
                        key_out <= key_vec(req.req_key, 1'b0);
`endif
                    end
                end
`ifdef KEY_GEN_BOUNCE_EN
                ST_PRESS_BOUNCE: begin
                    if (r_cnt == BOUNCE_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                        key_out <= key_vec(r_idx, 1'b0);
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        key_out <= key_vec(r_idx, w_bounce);
                    end
                end
`endif
                ST_HOLD: begin
                    if (r_cnt == r_hold) begin
`ifdef KEY_GEN_BOUNCE_EN
                        r_state <= ST_REL_BOUNCE;
                        r_cnt   <= '0;
                        key_out <= key_vec(r_idx, w_bounce);
`else
                        r_state <= ST_DONE;
                        key_out <= '1;
                        done    <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef KEY_GEN_BOUNCE_EN
                ST_REL_BOUNCE: begin
                    if (r_cnt == BOUNCE_LAST) begin
                        r_state <= ST_DONE;
                        key_out <= '1;
                        done    <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        key_out <= key_vec(r_idx, w_bounce);
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
